// File: rtl/song_rom_arbiter.sv
// Round-robin arbiter sharing one single-port song ROM between N_REQ voice sequencers.
// Issues one read per cycle and routes each returned word to the requester that issued it.
module song_rom_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int ROM_LATENCY = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*ADDR_W-1:0] i_addr,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [N_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]       o_rdata,
    output logic                    o_rom_en,
    output logic [ADDR_W-1:0]       o_rom_addr,
    input  logic [DATA_W-1:0]       i_rom_data
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]                    r_ptr;
    logic [ROM_LATENCY-1:0]              r_pv;
    logic [ROM_LATENCY-1:0][PTR_W-1:0]   r_pid;
    logic [N_REQ-1:0]                    r_rvalid;
    logic [DATA_W-1:0]                   r_rdata;

    logic                                w_any;
    logic                                w_issue;
    logic [PTR_W-1:0]                    w_win;

    // Scan requesters starting at the pointer, wrapping past N_REQ-1 to 0.
    always_comb begin
        int unsigned k;
        k     = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = 32'(r_ptr) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!w_any && i_req[k]) begin
                w_any = 1'b1;
                w_win = PTR_W'(k);
            end
        end
    end

    assign w_issue    = w_any && !i_rst;
    assign o_gnt      = w_issue ? (N_REQ'(1) << w_win) : '0;
    assign o_rom_en   = w_issue;
    assign o_rom_addr = w_issue ? i_addr[32'(w_win)*ADDR_W +: ADDR_W] : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_win == PTR_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
        end
    end

    // Valid+id pipe mirrors the ROM latency so returns line up with i_rom_data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pv  <= '0;
            r_pid <= '0;
        end else begin
            r_pv[0]  <= w_issue;
            r_pid[0] <= w_win;
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                r_pv[i]  <= r_pv[i-1];
                r_pid[i] <= r_pid[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= r_pv[ROM_LATENCY-1] ? (N_REQ'(1) << r_pid[ROM_LATENCY-1]) : '0;
            if (r_pv[ROM_LATENCY-1]) begin
                r_rdata <= i_rom_data;
            end
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;

endmodule

// File: tb/tb_song_rom_arbiter.sv
// Bench for song_rom_arbiter: directed scenarios plus rule-abiding random requesters,
// checked against a cycle-level scoreboard of grants and scheduled returns.
module tb_song_rom_arbiter;

    localparam int N    = 4;
    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [N-1:0]          req;
    logic [N-1:0][AW-1:0]  addr;
    logic [N-1:0]          gnt;
    logic [N-1:0]          rvalid;
    logic [DW-1:0]         rdata;
    logic                  rom_en;
    logic [AW-1:0]         rom_addr;
    logic [DW-1:0]         rom_q;

    logic [N-1:0]          req3;
    logic [N-1:0][AW-1:0]  addr3;
    logic [N-1:0]          gnt3;
    logic [N-1:0]          rvalid3;
    logic [DW-1:0]         rdata3;
    logic                  rom_en3;
    logic [AW-1:0]         rom_addr3;
    logic [DW-1:0]         rp3 [LAT3];

    int tests = 0;
    int fails = 0;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return {a ^ 8'h5A, (~a) + 8'h31};
    endfunction

    song_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(LAT)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr),
        .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
        .o_rom_en(rom_en), .o_rom_addr(rom_addr), .i_rom_data(rom_q)
    );

    song_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(LAT3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_req(req3), .i_addr(addr3),
        .o_gnt(gnt3), .o_rvalid(rvalid3), .o_rdata(rdata3),
        .o_rom_en(rom_en3), .o_rom_addr(rom_addr3), .i_rom_data(rp3[LAT3-1])
    );

    // ROM models: one-cycle and three-cycle read latency.
    always @(posedge clk) begin
        if (rom_en) rom_q <= rom_f(rom_addr);
        rp3[0] <= rom_f(rom_addr3);
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end

    // Scoreboard: expected return per future cycle, indexed by cycle number mod 8.
    int unsigned    cyc = 0;
    int unsigned    mptr = 0;
    int             mwin = -1;
    bit             warm = 0;
    logic [DW-1:0]  m_last = '0;
    bit             sv  [8];
    int             sid [8];
    logic [AW-1:0]  sa  [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        logic          ee;
        logic [N-1:0]  erv;
        logic [DW-1:0] erd;
        int unsigned   slot;
        #1;
        eg = '0; ea = '0; ee = 1'b0; mwin = -1;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (mwin < 0 && req[(mptr + i) % N]) mwin = int'((mptr + i) % N);
            end
        end
        if (mwin >= 0) begin
            eg = N'(1) << mwin;
            ee = 1'b1;
            ea = addr[mwin];
        end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rom_en", 32'(rom_en), 32'(ee));
        chk("rom_addr", 32'(rom_addr), 32'(ea));
        if (warm) begin
            slot = cyc % 8;
            if (sv[slot]) begin
                erv = N'(1) << sid[slot];
                erd = rom_f(sa[slot]);
                m_last = erd;
            end else begin
                erv = '0;
                erd = m_last;
            end
            chk("rvalid", 32'(rvalid), 32'(erv));
            chk("rdata", 32'(rdata), 32'(erd));
        end
        @(posedge clk);
        sv[cyc % 8] = 0;
        if (rst) begin
            for (int i = 0; i < 8; i++) sv[i] = 0;
            m_last = '0;
            mptr = 0;
            warm = 1;
        end else if (mwin >= 0) begin
            slot = (cyc + LAT + 1) % 8;
            sv[slot]  = 1;
            sid[slot] = mwin;
            sa[slot]  = addr[mwin];
            mptr = (int'(mwin) + 1) % N;
        end
        cyc++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < 8; i++) sv[i] = 0;
        rst = 1'b1; req = '0; addr = '0; req3 = '0; addr3 = '0;
        step(); step();
        rst = 1'b0;

        // Single request on port 2
        req = 4'b0100; addr[2] = 8'h12;
        step();
        req = '0;
        repeat (3) step();

        // All four continuously from reset
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'hF; addr = {8'h44, 8'h33, 8'h22, 8'h11};
        repeat (8) step();
        req = '0;
        repeat (3) step();

        // Move ptr to 2, then ports 0 and 3 only; then confirm ptr landed on 1
        req = 4'b0010; addr[1] = 8'h5C;
        step();
        req = 4'b1001; addr[0] = 8'hA0; addr[3] = 8'h3F;
        step();
        req[3] = 1'b0;
        step();
        req = '0;
        step();
        req = 4'hF;
        step();
        req = '0;
        repeat (3) step();

        // Back-to-back 8'h00 then 8'hFF
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0011; addr[0] = 8'h00; addr[1] = 8'hFF;
        step();
        req[0] = 1'b0;
        step();
        req = '0;
        repeat (3) step();

        // Reset with reads in flight; next grant must go to port 0
        req = 4'b0011; addr[0] = 8'h0A; addr[1] = 8'h0B;
        step();
        req[0] = 1'b0;
        step();
        req = '0; rst = 1'b1;
        step();
        rst = 1'b0; req = 4'hF;
        step();
        req = '0;
        repeat (3) step();

        // Random requesters obeying the hold-until-grant rule
        repeat (400) begin
            rst = ($urandom % 64) == 0;
            for (int k = 0; k < N; k++) begin
                if (k == mwin) begin
                    req[k]  = 1'($urandom % 2);
                    addr[k] = AW'($urandom);
                end else if (!req[k]) begin
                    req[k]  = ($urandom % 3) == 0;
                    addr[k] = (($urandom % 8) == 0) ? 8'hFF : AW'($urandom);
                end
            end
            step();
        end
        rst = 1'b0; req = '0;
        repeat (3) step();

        // Three-cycle ROM: return visible exactly 4 cycles after grant
        req3 = 4'b0010; addr3[1] = 8'h77;
        #1;
        chk("lat3_gnt", 32'(gnt3), 32'h2);
        chk("lat3_addr", 32'(rom_addr3), 32'h77);
        @(posedge clk); #1;
        req3 = '0;
        n = 1;
        while (n < 10 && !rvalid3[1]) begin
            @(posedge clk); #1;
            n++;
        end
        chk("lat3_delay", 32'(n), 32'd4);
        chk("lat3_rvalid", 32'(rvalid3), 32'h2);
        chk("lat3_rdata", 32'(rdata3), 32'(rom_f(8'h77)));
        @(posedge clk); #1;
        chk("lat3_pulse_end", 32'(rvalid3), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
